// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose: shared opcodes, ALU-op and forward-select encodings, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Purpose: opcode -> control word decoder for the ID stage.
// Latency: purely combinational, zero cycles.
// Backpressure: none; unknown opcodes decode to a bubble and raise illegal_o.
module pipe_ctrl_decode
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit EN_ADDI = 1'b1
) (
  input  logic       valid_i,
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  // Map each supported opcode to its control bits; everything else is a bubble.
  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    illegal_o = 1'b0;
    if (valid_i) begin
      case (opcode_i)
        OP_R: begin
          ctrl_o.reg_dst   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_FUNCT;
        end
        OP_LW: begin
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.alu_op     = ALU_ADD;
        end
        OP_SW: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_op    = ALU_ADD;
        end
        OP_BEQ: begin
          ctrl_o.branch = 1'b1;
          ctrl_o.alu_op = ALU_SUB;
        end
        OP_ADDI: begin
          if (EN_ADDI) begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
          end else begin
            illegal_o = 1'b1;
          end
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline control: ID/EX, EX/MEM, MEM/WB control stages, forwarding, load-use stall, branch flush.
// Latency: control appears on ex_* one cycle after ID, mem_* two, wb_* three; fwd/stall/flush are combinational.
// Backpressure: stall holds PC and IF/ID on a load-use hazard; flush (taken branch) overrides stall.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16,
  parameter bit EN_ADDI = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              ex_regDst,
  output logic              ex_aluSrc,
  output logic              ex_branch,
  output logic [1:0]        ex_aluOp,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic              wb_regWrite,
  output logic              wb_memToReg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_store,
  output logic              stall,
  output logic              flush,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] dst;
  } memwb_t;

  idex_t             idex_q, idex_d;
  exmem_t            exmem_q, exmem_d;
  memwb_t            memwb_q, memwb_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  ctrl_t             id_ctrl;
  logic              id_illegal;
  logic [REG_AW-1:0] id_dst;
  logic              id_uses_rt;
  logic              load_use;

  pipe_ctrl_decode #(.EN_ADDI(EN_ADDI)) u_decode (
    .valid_i   (id_valid),
    .opcode_i  (id_opcode),
    .ctrl_o    (id_ctrl),
    .illegal_o (id_illegal)
  );

  assign id_dst     = id_ctrl.reg_dst ? id_rd : id_rt;
  // Only R-type and beq read rt in EX; a sw reads rt as store data, which
  // fwd_store covers from MEM/WB, so it never needs to stall on rt.
  assign id_uses_rt = (id_opcode == OP_R) || (id_opcode == OP_BEQ);

  assign load_use = idex_q.ctrl.mem_read && (idex_q.dst != '0) && id_valid &&
                    ((idex_q.dst == id_rs) || (id_uses_rt && (idex_q.dst == id_rt)));

  assign flush = ex_branch_taken;
  assign stall = load_use && !ex_branch_taken;

  // EX/MEM has priority over MEM/WB because it holds the younger result.
  assign fwd_a = ((idex_q.rs != '0) && exmem_q.reg_write && (exmem_q.dst == idex_q.rs)) ? FWD_EXMEM :
                 ((idex_q.rs != '0) && memwb_q.reg_write && (memwb_q.dst == idex_q.rs)) ? FWD_MEMWB :
                 FWD_RF;
  assign fwd_b = ((idex_q.rt != '0) && exmem_q.reg_write && (exmem_q.dst == idex_q.rt)) ? FWD_EXMEM :
                 ((idex_q.rt != '0) && memwb_q.reg_write && (memwb_q.dst == idex_q.rt)) ? FWD_MEMWB :
                 FWD_RF;
  assign fwd_store = exmem_q.mem_write && memwb_q.reg_write && (memwb_q.dst != '0) &&
                     (exmem_q.rt == memwb_q.dst);

  // Next-state for the stage registers, sticky illegal flag and saturating counters.
  always_comb begin
    idex_d = '0;
    if (id_valid && !stall && !flush) begin
      idex_d.ctrl = id_ctrl;
      idex_d.rs   = id_rs;
      idex_d.rt   = id_rt;
      idex_d.dst  = id_dst;
    end

    exmem_d.mem_read   = idex_q.ctrl.mem_read;
    exmem_d.mem_write  = idex_q.ctrl.mem_write;
    exmem_d.reg_write  = idex_q.ctrl.reg_write;
    exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
    exmem_d.rt         = idex_q.rt;
    exmem_d.dst        = idex_q.dst;

    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.mem_to_reg = exmem_q.mem_to_reg;
    memwb_d.dst        = exmem_q.dst;

    illegal_d   = illegal_q | id_illegal;
    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // State registers with synchronous reset that drops every in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_regDst    = idex_q.ctrl.reg_dst;
  assign ex_aluSrc    = idex_q.ctrl.alu_src;
  assign ex_branch    = idex_q.ctrl.branch;
  assign ex_aluOp     = idex_q.ctrl.alu_op;
  assign mem_memRead  = exmem_q.mem_read;
  assign mem_memWrite = exmem_q.mem_write;
  assign wb_regWrite  = memwb_q.reg_write;
  assign wb_memToReg  = memwb_q.mem_to_reg;
  assign illegal_op   = illegal_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: self-checking bench for pipe_hazard_ctrl (decode, forwarding, stall, flush, reset).
// Latency: one vector per clock, outputs sampled on the falling edge.
// Backpressure: none; stimulus is open-loop, stall is checked as an output.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [5:0]    id_opcode;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          ex_branch_taken;
  logic          ex_regDst, ex_aluSrc, ex_branch;
  logic [1:0]    ex_aluOp;
  logic          mem_memRead, mem_memWrite;
  logic          wb_regWrite, wb_memToReg;
  logic [1:0]    fwd_a, fwd_b;
  logic          fwd_store, stall, flush, illegal_op;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .EN_ADDI(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_regDst       (ex_regDst),
    .ex_aluSrc       (ex_aluSrc),
    .ex_branch       (ex_branch),
    .ex_aluOp        (ex_aluOp),
    .mem_memRead     (mem_memRead),
    .mem_memWrite    (mem_memWrite),
    .wb_regWrite     (wb_regWrite),
    .wb_memToReg     (wb_memToReg),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .fwd_store       (fwd_store),
    .stall           (stall),
    .flush           (flush),
    .illegal_op      (illegal_op),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exc = {regDst, aluSrc, branch}; mem = {memRead, memWrite}; wb = {regWrite, memToReg}
  typedef struct packed {
    logic [2:0]    exc;
    logic [1:0]    aop;
    logic [1:0]    mem;
    logic [1:0]    wb;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          fs;
    logic          st;
    logic          fl;
    logic          il;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  typedef struct {
    logic          pr;
    logic          v;
    logic [5:0]    op;
    logic [AW-1:0] rs, rt, rd;
    logic          bt;
    exp_t          e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic pr, v, input logic [5:0] op,
                              input logic [AW-1:0] rs, rt, rd, input logic bt,
                              input logic [2:0] exc, input logic [1:0] aop, mem, wb, fa, fb,
                              input logic fs, st, fl, il, input logic [CW-1:0] sc, fc);
    vec_t t;
    t.pr = pr; t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.bt = bt;
    t.e  = {exc, aop, mem, wb, fa, fb, fs, st, fl, il, sc, fc};
    return t;
  endfunction

  task automatic add(input logic pr, v, input logic [5:0] op,
                     input logic [AW-1:0] rs, rt, rd, input logic bt,
                     input logic [2:0] exc, input logic [1:0] aop, mem, wb, fa, fb,
                     input logic fs, st, fl, il, input logic [CW-1:0] sc, fc);
    tbl.push_back(mk(pr, v, op, rs, rt, rd, bt, exc, aop, mem, wb, fa, fb, fs, st, fl, il, sc, fc));
  endtask

  function automatic exp_t sample();
    return {ex_regDst, ex_aluSrc, ex_branch, ex_aluOp, mem_memRead, mem_memWrite,
            wb_regWrite, wb_memToReg, fwd_a, fwd_b, fwd_store, stall, flush,
            illegal_op, stall_cnt, flush_cnt};
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("ex=%b aop=%b mem=%b wb=%b fa=%b fb=%b fs=%b st=%b fl=%b il=%b sc=%0d fc=%0d",
                     x.exc, x.aop, x.mem, x.wb, x.fa, x.fb, x.fs, x.st, x.fl, x.il, x.sc, x.fc);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; id_valid = 1'b0; id_opcode = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_branch_taken = 1'b0;
  endtask

  task automatic step(input vec_t t, input logic rst_in, input string nm);
    exp_t got, want;
    @(posedge clk);
    #1;
    reset = rst_in; id_valid = t.v; id_opcode = t.op;
    id_rs = t.rs; id_rt = t.rt; id_rd = t.rd; ex_branch_taken = t.bt;
    sb.push_back(t.e);
    @(negedge clk);
    got  = sample();
    want = sb.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %s | want %s", nm, fmt(got), fmt(want));
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opcode = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_branch_taken = 1'b0;

    // Decode: R, lw, sw, beq, addi, then illegal opcode 2.
    add(1,1,OP_R,   1,2,3,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_LW,  1,4,0,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_SW,  1,5,0,0, 3'b010,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_BEQ, 6,7,0,0, 3'b010,2'b00,2'b10,2'b10,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_ADDI,1,8,0,0, 3'b001,2'b01,2'b01,2'b11,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,6'd2,   0,0,0,0, 3'b010,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,1, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b000,2'b00,2'b00,2'b10,2'b00,2'b00, 0,0,0,1, 0,0);
    // EX/MEM result wins over an older MEM/WB write to the same register.
    add(1,1,OP_R,   1,2,3,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_R,   1,2,3,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_R,   3,1,4,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b100,2'b10,2'b00,2'b10,2'b10,2'b00, 0,0,0,0, 0,0);
    // add $3 then add $4,$3,$3: forward from EX/MEM.
    add(1,1,OP_R,   1,2,3,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_R,   3,3,4,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b100,2'b10,2'b00,2'b00,2'b10,2'b10, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b000,2'b00,2'b00,2'b10,2'b00,2'b00, 0,0,0,0, 0,0);
    // One independent instruction between: forward from MEM/WB.
    add(1,1,OP_R,   1,2,3,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_R,   7,8,9,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_R,   3,3,4,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b100,2'b10,2'b00,2'b10,2'b01,2'b01, 0,0,0,0, 0,0);
    // Writer $0 never forwards.
    add(1,1,OP_R,   1,2,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_R,   0,0,5,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    // lw $5 then add $6,$5,$1: one stall, bubble, then MEM/WB forward.
    add(1,1,OP_LW,  1,5,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_R,   5,1,6,0, 3'b010,2'b00,2'b00,2'b00,2'b00,2'b00, 0,1,0,0, 0,0);
    add(0,1,OP_R,   5,1,6,0, 3'b000,2'b00,2'b10,2'b00,2'b00,2'b00, 0,0,0,0, 1,0);
    add(0,0,6'd0,   0,0,0,0, 3'b100,2'b10,2'b00,2'b11,2'b01,2'b00, 0,0,0,0, 1,0);
    // lw $7 then sw $7: no stall, store data forwarded while sw is in MEM.
    add(1,1,OP_LW,  1,7,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_SW,  2,7,0,0, 3'b010,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b010,2'b00,2'b10,2'b00,2'b00,2'b10, 0,0,0,0, 0,0);
    add(0,0,6'd0,   0,0,0,0, 3'b000,2'b00,2'b01,2'b11,2'b00,2'b00, 1,0,0,0, 0,0);
    // beq reading the loaded register through rt does stall.
    add(1,1,OP_LW,  1,5,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_BEQ, 2,5,0,0, 3'b010,2'b00,2'b00,2'b00,2'b00,2'b00, 0,1,0,0, 0,0);
    add(0,1,OP_BEQ, 2,5,0,0, 3'b000,2'b00,2'b10,2'b00,2'b00,2'b00, 0,0,0,0, 1,0);
    // Branch taken during a load-use hazard: flush wins, stall suppressed.
    add(1,1,OP_LW,  1,5,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0);
    add(0,1,OP_BEQ, 2,5,0,1, 3'b010,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 0,0);
    add(0,1,OP_R,   1,2,3,0, 3'b000,2'b00,2'b10,2'b00,2'b00,2'b00, 0,0,0,0, 0,1);
    // Flush counter saturates at 3.
    add(1,0,6'd0,   0,0,0,1, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 0,0);
    add(0,0,6'd0,   0,0,0,1, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 0,1);
    add(0,0,6'd0,   0,0,0,1, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 0,2);
    add(0,0,6'd0,   0,0,0,1, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 0,3);
    add(0,0,6'd0,   0,0,0,1, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1,0, 0,3);
    add(0,0,6'd0,   0,0,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,3);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pr) do_reset();
      step(tbl[i], 1'b0, $sformatf("row%0d", i));
    end

    // Reset mid-stream with lw/sw in flight and the flush counter saturated.
    step(mk(0,1,OP_LW,1,5,0,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,3), 1'b0, "midrst_lw");
    step(mk(0,1,OP_SW,1,5,0,0, 3'b010,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,3), 1'b0, "midrst_sw");
    step(mk(0,1,OP_R, 5,5,6,0, 3'b010,2'b00,2'b10,2'b00,2'b00,2'b10, 0,0,0,0, 0,3), 1'b1, "midrst_assert");
    step(mk(0,1,OP_R, 5,5,6,0, 3'b000,2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0), 1'b0, "midrst_cleared");
    step(mk(0,0,6'd0, 0,0,0,0, 3'b100,2'b10,2'b00,2'b00,2'b00,2'b00, 0,0,0,0, 0,0), 1'b0, "midrst_nohazard");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
